// File: rtl/rate_ctrl_pkg.sv
// Shared definitions for the rate controller: state encoding, counter widths,
// default tick periods and the speed-to-period selection helper.
package rate_ctrl_pkg;

    localparam int unsigned CNT_W      = 26;
    localparam int unsigned TICK_CNT_W = 8;

    // Default tick periods in clk cycles for speeds 0..3.
    localparam int unsigned DEF_PERIOD0 = 32'd62500000;
    localparam int unsigned DEF_PERIOD1 = 32'd31250000;
    localparam int unsigned DEF_PERIOD2 = 32'd15625000;
    localparam int unsigned DEF_PERIOD3 = 32'd6250000;

    localparam logic [CNT_W-1:0]      CNT_ONE      = 26'd1;
    localparam logic [TICK_CNT_W-1:0] TICK_CNT_ONE = 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_STEP  = 2'd3
    } state_e;

    // Map a 2-bit speed request onto one of the four configured periods.
    function automatic logic [CNT_W-1:0] sel_period(
        input logic [1:0]       speed,
        input logic [CNT_W-1:0] p0,
        input logic [CNT_W-1:0] p1,
        input logic [CNT_W-1:0] p2,
        input logic [CNT_W-1:0] p3
    );
        logic [CNT_W-1:0] res;
        case (speed)
            2'd0:    res = p0;
            2'd1:    res = p1;
            2'd2:    res = p2;
            2'd3:    res = p3;
            default: res = p0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rate_ctrl_tick_counter.sv
// Period counter: counts while enabled and wraps to zero at period-1,
// flagging the wrap combinationally so the owner can register the tick.
module tick_counter
    import rate_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [CNT_W-1:0] period,
    output logic             wrap,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_end_s;

    // Detect the last count of the current period and qualify it into a wrap.
    always_comb begin
        at_end_s = (cnt_q == (period - CNT_ONE));
        wrap     = en && at_end_s && !clear;
    end

    // Next count: clear dominates, wrap returns to zero, otherwise count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/rate_ctrl.sv
// Rate controller: IDLE/RUN/PAUSE/STEP sequencer issuing one-cycle tick pulses
// at a speed-selected period, with a running 8-bit tick count.
module rate_ctrl
    import rate_ctrl_pkg::*;
#(
    parameter int unsigned PERIOD0 = DEF_PERIOD0,
    parameter int unsigned PERIOD1 = DEF_PERIOD1,
    parameter int unsigned PERIOD2 = DEF_PERIOD2,
    parameter int unsigned PERIOD3 = DEF_PERIOD3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  stop,
    input  logic                  step,
    input  logic [1:0]            speed,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_cnt,
    output logic [1:0]            state
);

    localparam logic [CNT_W-1:0] P0_C = CNT_W'(PERIOD0);
    localparam logic [CNT_W-1:0] P1_C = CNT_W'(PERIOD1);
    localparam logic [CNT_W-1:0] P2_C = CNT_W'(PERIOD2);
    localparam logic [CNT_W-1:0] P3_C = CNT_W'(PERIOD3);

    state_e                state_q;
    state_e                state_d;
    logic                  tick_q;
    logic                  tick_d;
    logic [TICK_CNT_W-1:0] tick_cnt_q;
    logic [TICK_CNT_W-1:0] tick_cnt_d;
    logic [CNT_W-1:0]      period_q;
    logic [CNT_W-1:0]      period_d;

    logic                  cnt_en_s;
    logic                  cnt_clr_s;
    logic                  cnt_err_s;
    logic                  load_period_s;
    logic                  step_tick_s;
    logic                  wrap_s;
    logic [CNT_W-1:0]      cnt_s;

    tick_counter u_tick_counter (
        .clk    (clk),
        .rst    (rst),
        .en     (cnt_en_s),
        .clear  (cnt_clr_s),
        .period (period_q),
        .wrap   (wrap_s),
        .cnt    (cnt_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; requests are resolved stop > pause > start > step,
    // so a pause raised together with start keeps IDLE/PAUSE where they are.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else if (start) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_STEP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter corruption guard: a count at or beyond the period can only come
    // from an upset, so it is cleared rather than left to run to 2^26.
    always_comb begin
        cnt_err_s = (cnt_s >= period_q);
    end

    // FSM outputs: counter enable/clear, period load on start, step pulse request.
    // The counter only advances when RUN continues into RUN, so a pause that
    // lands on the last count holds it there without wrapping.
    always_comb begin
        cnt_en_s      = 1'b0;
        cnt_clr_s     = cnt_err_s;
        load_period_s = 1'b0;
        step_tick_s   = 1'b0;
        if (stop) begin
            cnt_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (state_d == ST_RUN) begin
                        cnt_clr_s     = 1'b1;
                        load_period_s = 1'b1;
                    end else begin
                        load_period_s = 1'b0;
                    end
                end
                ST_RUN: begin
                    cnt_en_s = (state_d == ST_RUN);
                end
                ST_PAUSE: begin
                    cnt_en_s = 1'b0;
                end
                ST_STEP: begin
                    step_tick_s = 1'b1;
                end
                default: begin
                    cnt_clr_s = 1'b1;
                end
            endcase
        end
    end

    // Datapath next state: tick pulse, tick count and period latching.
    // The period is only re-sampled at a wrap or on entry from IDLE so a speed
    // change never alters the period already in progress.
    always_comb begin
        tick_d = wrap_s || step_tick_s;
        if (load_period_s || wrap_s) begin
            period_d = sel_period(speed, P0_C, P1_C, P2_C, P3_C);
        end else begin
            period_d = period_q;
        end
        if (stop) begin
            tick_cnt_d = '0;
        end else if (tick_d) begin
            tick_cnt_d = tick_cnt_q + TICK_CNT_ONE;
        end else begin
            tick_cnt_d = tick_cnt_q;
        end
    end

    // Datapath registers; reset abandons any period in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_q     <= 1'b0;
            tick_cnt_q <= '0;
            period_q   <= P0_C;
        end else begin
            tick_q     <= tick_d;
            tick_cnt_q <= tick_cnt_d;
            period_q   <= period_d;
        end
    end

    assign tick     = tick_q;
    assign tick_cnt = tick_cnt_q;
    assign state    = state_q;

endmodule
